// File: rtl/mdu.sv
// mdu: 32-bit iterative multiply/divide unit holding HI/LO.
// The divider datapath is compiled only when MDU_DIV_EN is defined.
module mdu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
`ifdef MDU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif
    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [63:0] acc, acc_nx, mul_res;
    logic [31:0] m, abs_a, abs_b, hi_res, lo_res;
    logic [32:0] sum;
    logic        is_div, neg_q, sgn, commit;
    assign sgn     = ~op[0];
    assign abs_a   = (sgn && SrcA[31]) ? -SrcA : SrcA;
    assign abs_b   = (sgn && SrcB[31]) ? -SrcB : SrcB;
    assign busy    = state != IDLE;
    assign mul_res = neg_q ? -acc : acc;
    assign sum     = {1'b0, acc[63:32]} + {1'b0, acc[0] ? m : 32'd0};
    assign commit  = state == FIX && (DIV_EN || !is_div);
`ifdef MDU_DIV_EN
    // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic        neg_r, ge;
    logic [32:0] shifted;
    assign shifted = acc[63:31];
    assign ge      = shifted >= {1'b0, m};
    assign acc_nx  = !is_div ? {sum, acc[31:1]} :
                     ge ? {shifted[31:0] - m, acc[30:0], 1'b1} : {shifted[31:0], acc[30:0], 1'b0};
    assign hi_res  = !is_div ? mul_res[63:32] : neg_r ? -acc[63:32] : acc[63:32];
    assign lo_res  = !is_div ? mul_res[31:0] : neg_q ? -acc[31:0] : acc[31:0];
`else
    assign acc_nx  = {sum, acc[31:1]};
    assign hi_res  = mul_res[63:32];
    assign lo_res  = mul_res[31:0];
`endif
    always_comb begin
        state_nx = state;
        if (state == IDLE && start)
            state_nx = (op[1] && !DIV_EN) ? FIX : RUN;
        else if (state == RUN && cnt == 5'd31)
            state_nx = FIX;
        else if (state == FIX)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
`ifdef MDU_DIV_EN
            neg_r  <= 1'b0;
`endif
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= state == FIX;
            if (state == IDLE && start) begin
                cnt    <= '0;
                is_div <= op[1];
                // a zero divisor keeps the all-ones quotient unsigned-looking
                neg_q  <= sgn && (SrcA[31] ^ SrcB[31]) && |SrcB;
`ifdef MDU_DIV_EN
                neg_r  <= sgn && SrcA[31];
`endif
                m      <= op[1] ? abs_b : abs_a;
                acc    <= {32'd0, op[1] ? abs_a : abs_b};
            end else if (state == IDLE) begin
                if (mthi) HI <= SrcA;
                if (mtlo) LO <= SrcA;
            end
            if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt + 5'd1;
            end
            if (commit) begin
                HI <= hi_res;
                LO <= lo_res;
            end
        end
    end
endmodule
